// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer:
// FSM state encoding and the width of the reused adder slice.
package adder_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between the datapath register file (master)
// and the nibble-serial adder sequencer (slave).
interface nibble_serial_adder_ctrl_if #(
  parameter int W = 16
);

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  modport master (
    output start, op_sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, op_sub, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );

endinterface

// File: rtl/nibble_serial_adder_ctrl_fa4.sv
// Existing 4-bit ripple-carry adder slice, purely combinational.
// Port order (c_out, sum, a, b, c_in) matches the legacy instantiations.
module FA_4bit
  import adder_ctrl_pkg::*;
(
  output logic             c_out,
  output logic [NIB_W-1:0] sum,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             c_in
);

  logic [NIB_W:0] carry;

  // Ripple the carry through four full adders, bit 0 first.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract performed one nibble per clock, LSB first, on a single
// shared 4-bit adder slice; result is held until the next accepted start.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave   bus
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state_q;
  state_t state_d;

  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     sum_r;
  logic [IDX_W-1:0] idx_q;
  logic             carry_r;
  logic             c_out_r;
  logic             overflow_r;

  logic [NIB_W-1:0] slice_a;
  logic [NIB_W-1:0] slice_b;
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cin;
  logic             slice_cout;

  logic             accept;
  logic             last_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus slice muxing; the slice sees all-zero inputs outside RUN.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_nib  = 1'b0;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        slice_a   = a_r[NIB_W*idx_q +: NIB_W];
        slice_b   = b_r[NIB_W*idx_q +: NIB_W];
        slice_cin = carry_r;
        if (idx_q == LAST_IDX) begin
          last_nib = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  FA_4bit u_slice (
    .c_out (slice_cout),
    .sum   (slice_sum),
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (slice_cin)
  );

  // Subtraction is a + ~b + 1, so b is inverted and the carry seeded at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      idx_q      <= '0;
      carry_r    <= 1'b0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept) begin
      a_r        <= bus.a;
      b_r        <= bus.op_sub ? ~bus.b : bus.b;
      carry_r    <= bus.op_sub ? 1'b1 : bus.c_in;
      idx_q      <= '0;
      sum_r      <= '0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (state_q == RUN) begin
      sum_r[NIB_W*idx_q +: NIB_W] <= slice_sum;
      carry_r                     <= slice_cout;
      if (last_nib) begin
        idx_q      <= '0;
        c_out_r    <= slice_cout;
        overflow_r <= (a_r[W-1] == b_r[W-1]) && (slice_sum[NIB_W-1] != a_r[W-1]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_r;
  assign bus.c_out    = c_out_r;
  assign bus.overflow = overflow_r;

endmodule
